// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle CPU core:
// opcodes, FSM states, instruction layout and sign extension.
package mcpu_pkg;

  localparam int RA = 4;

  localparam logic [3:0] OP_ADDI = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_BEQZ = 4'h2;
  localparam logic [3:0] OP_BNEZ = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_RDA,
    S_RDB,
    S_WB,
    S_HALT
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] d;
    logic [3:0] a;
    logic [3:0] b;
  } instr_t;

  function automatic logic [31:0] sx4(input logic [3:0] v);
    return {{28{v[3]}}, v};
  endfunction

  function automatic logic [31:0] sx8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/mcpu_core_alu.sv
// Combinational DW-wide ALU; unlisted opcodes add,
// which also serves ADDI and effective-address sums.
module mcpu_alu
  import mcpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result
);

  always_comb begin
    result = a + b;
    case (op)
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/mcpu_core.sv
// Multi-cycle CPU core: ROM fetch, external register-file RAM,
// stepped by clk2, with branches, jump and HALT.
module mcpu_core
  import mcpu_pkg::*;
#(
  parameter int DW       = 16,
  parameter int PW       = 5,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk2,
  output logic [PW-1:0] pc,
  input  logic [15:0]   instr,
  output logic [RA-1:0] DA,
  output logic [DW-1:0] DOUT,
  input  logic [DW-1:0] DIN,
  output logic          RD,
  output logic          WR,
  output logic [7:0]    led,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  instr_t        ir_q, ir_d;
  instr_t        inst_w;
  logic [DW-1:0] a_q, a_d;
  logic [RA-1:0] eff_q, eff_d;
  logic [RA-1:0] da_q, da_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          halted_q, halted_d;

  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [PW-1:0] pc_inc, pc_br;

  assign inst_w = instr;
  assign pc_inc = pc_q + PW'(1);
  assign pc_br  = pc_q + PW'(sx8({ir_q.a, ir_q.b}));

  // In RDA the ALU forms R[a]+sx4 for ADDI and LD/ST addressing.
  always_comb begin
    alu_op = ir_q.op;
    alu_a  = a_q;
    alu_b  = DIN;
    if (state_q == S_RDA) begin
      alu_op = OP_ADD;
      alu_a  = DIN;
      alu_b  = DW'(sx4(ir_q.b));
    end
  end

  mcpu_alu #(.DW(DW)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_res)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    eff_d    = eff_q;
    da_d     = da_q;
    dout_d   = dout_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    halted_d = halted_q;
    if (clk2) begin
      unique case (state_q)
        S_FETCH: begin
          state_d = S_DECODE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
        S_DECODE: begin
          ir_d = inst_w;
          case (inst_w.op)
            OP_ADDI, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_LD, OP_ST: begin
              state_d = S_RDA;
              da_d    = inst_w.a;
              rd_d    = 1'b1;
            end
            OP_BEQZ, OP_BNEZ: begin
              state_d = S_RDA;
              da_d    = inst_w.d;
              rd_d    = 1'b1;
            end
            OP_JMP: begin
              state_d = S_FETCH;
              pc_d = pc_q + PW'(sx12({inst_w.d, inst_w.a, inst_w.b}));
            end
            OP_HALT: begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
            default: begin
              state_d = S_FETCH;
              pc_d    = pc_inc;
            end
          endcase
        end
        S_RDA: begin
          a_d = DIN;
          case (ir_q.op)
            OP_ADDI: begin
              state_d = S_WB;
              da_d    = ir_q.d;
              dout_d  = alu_res;
              rd_d    = 1'b0;
              wr_d    = 1'b1;
            end
            OP_BEQZ: begin
              state_d = S_FETCH;
              rd_d    = 1'b0;
              pc_d    = (DIN == '0) ? pc_br : pc_inc;
            end
            OP_BNEZ: begin
              state_d = S_FETCH;
              rd_d    = 1'b0;
              pc_d    = (DIN != '0) ? pc_br : pc_inc;
            end
            OP_LD: begin
              state_d = S_RDB;
              da_d    = alu_res[RA-1:0];
            end
            OP_ST: begin
              state_d = S_RDB;
              eff_d   = alu_res[RA-1:0];
              da_d    = ir_q.d;
            end
            default: begin
              state_d = S_RDB;
              da_d    = ir_q.b;
            end
          endcase
        end
        S_RDB: begin
          state_d = S_WB;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          da_d    = ir_q.d;
          dout_d  = alu_res;
          if (ir_q.op == OP_LD) begin
            dout_d = DIN;
          end else if (ir_q.op == OP_ST) begin
            dout_d = DIN;
            da_d   = eff_q;
          end
        end
        S_WB: begin
          state_d = S_FETCH;
          wr_d    = 1'b0;
          pc_d    = pc_inc;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= PW'(RESET_PC);
      ir_q     <= '0;
      a_q      <= '0;
      eff_q    <= '0;
      da_q     <= '0;
      dout_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      eff_q    <= eff_d;
      da_q     <= da_d;
      dout_q   <= dout_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign DA     = da_q;
  assign DOUT   = dout_q;
  assign RD     = rd_q;
  assign WR     = wr_q;
  assign led    = {ir_q.op, ir_q.d};
  assign halted = halted_q;

endmodule

// File: tb/tb_mcpu_core.sv
// Bench for mcpu_core: ROM/RAM models, clk2 every third clk,
// instruction-level reference model and directed + random programs.
module tb_mcpu_core;

  localparam int DW   = 16;
  localparam int PW   = 5;
  localparam int NW   = 32;
  localparam int MASK = 32'hFFFF;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          clk2 = 1'b0;
  logic [PW-1:0] pc;
  logic [15:0]   instr;
  logic [3:0]    DA;
  logic [DW-1:0] DOUT, DIN;
  logic          RD, WR;
  logic [7:0]    led;
  logic          halted;

  logic [15:0]   rom [NW];
  logic [DW-1:0] ram [16];
  int            m_r [16];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         wr_step[$];
  logic [3:0] wr_da[$];
  int         rd_cnt;
  int         edges;

  mcpu_core #(.DW(DW), .PW(PW), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .clk2(clk2), .pc(pc), .instr(instr),
    .DA(DA), .DOUT(DOUT), .DIN(DIN), .RD(RD), .WR(WR),
    .led(led), .halted(halted)
  );

  assign instr = rom[pc];
  assign DIN   = ram[DA];

  initial forever #5 clk = ~clk;

  initial begin : g_clk2
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c = (c + 1) % 3;
      clk2 = (c == 0);
    end
  end

  // Register file commits at the step boundary ending the write step.
  initial forever begin
    @(posedge clk);
    if (WR && clk2) ram[DA] = DOUT;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    while (!clk2) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NW; i++) rom[i] = 16'hA000;
    for (int i = 0; i < 16; i++) ram[i] = '0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run(input int budget);
    edges = 0;
    rd_cnt = 0;
    wr_step.delete();
    wr_da.delete();
    while (!halted && edges < budget) begin
      step();
      edges++;
      if (WR) begin
        wr_step.push_back(edges + 1);
        wr_da.push_back(DA);
      end
      if (RD) rd_cnt++;
    end
  endtask

  function automatic int wrap(input int v);
    return ((v % NW) + NW) % NW;
  endfunction

  // Instruction-level model: whole instructions, step costs per opcode.
  function automatic void iss(output int steps, output int hpc,
                              output bit ok);
    int p, op, d, a, b, s4, s8, s12, e, x, y;
    logic [15:0] ins;
    p = 0; steps = 0; hpc = 0; ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      ins = rom[p];
      op = int'(ins[15:12]);
      d = int'(ins[11:8]);
      a = int'(ins[7:4]);
      b = int'(ins[3:0]);
      s4 = b;
      if (s4 > 7) s4 -= 16;
      s8 = int'(ins[7:0]);
      if (s8 > 127) s8 -= 256;
      s12 = int'(ins[11:0]);
      if (s12 > 2047) s12 -= 4096;
      x = m_r[a];
      y = m_r[b];
      case (op)
        0: begin m_r[d] = (x + s4) & MASK; steps += 4; p = wrap(p + 1); end
        1: begin m_r[d] = (x + y) & MASK; steps += 5; p = wrap(p + 1); end
        4: begin m_r[d] = (x - y) & MASK; steps += 5; p = wrap(p + 1); end
        5: begin m_r[d] = x & y; steps += 5; p = wrap(p + 1); end
        6: begin m_r[d] = x | y; steps += 5; p = wrap(p + 1); end
        7: begin m_r[d] = x ^ y; steps += 5; p = wrap(p + 1); end
        8: begin
          e = (x + s4) & 15;
          m_r[d] = m_r[e]; steps += 5; p = wrap(p + 1);
        end
        9: begin
          e = (x + s4) & 15;
          m_r[e] = m_r[d]; steps += 5; p = wrap(p + 1);
        end
        2: begin steps += 3; p = wrap(m_r[d] == 0 ? p + s8 : p + 1); end
        3: begin steps += 3; p = wrap(m_r[d] != 0 ? p + s8 : p + 1); end
        15: begin steps += 2; p = wrap(p + s12); end
        10: begin steps += 2; hpc = p; ok = 1'b1; return; end
        default: begin steps += 2; p = wrap(p + 1); end
      endcase
    end
  endfunction

  task automatic go(input string tag);
    int steps, hpc;
    bit ok;
    for (int i = 0; i < 16; i++) m_r[i] = int'(ram[i]);
    iss(steps, hpc, ok);
    release_rst();
    run(steps + 20);
    chk({tag, ":halted"}, 32'(halted), 32'(ok));
    chk({tag, ":pc"}, 32'(pc), hpc);
    chk({tag, ":steps"}, edges, steps);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s:r%0d", tag, i), 32'(ram[i]), m_r[i]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ":pc"}, 32'(pc), 0);
    chk({tag, ":DA"}, 32'(DA), 0);
    chk({tag, ":DOUT"}, 32'(DOUT), 0);
    chk({tag, ":RD"}, 32'(RD), 0);
    chk({tag, ":WR"}, 32'(WR), 0);
    chk({tag, ":led"}, 32'(led), 0);
    chk({tag, ":halted"}, 32'(halted), 0);
  endtask

  logic [15:0] alu_prog [4];
  int          alu_exp  [4];
  int          bad;
  int          g_steps, g_hpc;
  bit          g_ok;

  initial begin
    alu_prog = '{16'h4654, 16'h5654, 16'h6654, 16'h7654};
    alu_exp  = '{4, 1, 13, 12};

    clear_mem();
    hold_reset();
    chk_reset("reset");

    // ADDI, ADDI, ADD with write-pulse timing
    clear_mem();
    rom[0] = 16'h0101; rom[1] = 16'h0211; rom[2] = 16'h1312;
    go("t1");
    chk("t1:r3", 32'(ram[3]), 3);
    chk("t1:nwr", wr_step.size(), 3);
    if (wr_step.size() == 3) begin
      chk("t1:wr0", wr_step[0], 4);
      chk("t1:wr1", wr_step[1], 8);
      chk("t1:wr2", wr_step[2], 13);
    end
    chk("t1:rdsteps", rd_cnt, 4);

    for (int k = 0; k < 4; k++) begin
      hold_reset();
      clear_mem();
      ram[4] = 16'd5; ram[5] = 16'd9;
      rom[0] = alu_prog[k];
      go($sformatf("t2_%0d", k));
      chk($sformatf("t2_%0d:r6", k), 32'(ram[6]), alu_exp[k]);
    end

    hold_reset();
    clear_mem();
    ram[1] = 16'd2; ram[3] = 16'h1234;
    rom[0] = 16'h8711; rom[1] = 16'h971F;
    go("t3");
    chk("t3:r7", 32'(ram[7]), 32'h1234);
    chk("t3:r1", 32'(ram[1]), 32'h1234);
    chk("t3:nwr", wr_step.size(), 2);
    if (wr_da.size() == 2) chk("t3:st_da", 32'(wr_da[1]), 1);

    hold_reset();
    clear_mem();
    for (int i = 0; i < 5; i++) rom[i] = 16'hB000;
    rom[5] = 16'h2003;
    go("t4beqz");
    chk("t4beqz:pc8", 32'(pc), 8);

    hold_reset();
    clear_mem();
    for (int i = 0; i < 5; i++) rom[i] = 16'hB000;
    rom[5] = 16'h3003;
    go("t4bnez");
    chk("t4bnez:pc6", 32'(pc), 6);

    hold_reset();
    clear_mem();
    rom[0] = 16'hFFFF;
    go("t4jmp");
    chk("t4jmp:pc31", 32'(pc), 31);

    hold_reset();
    clear_mem();
    for (int i = 0; i < 9; i++) rom[i] = 16'hB000;
    go("t5");
    chk("t5:led", 32'(led), 32'hA0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (WR || pc != 5'd9 || !halted) bad++;
    end
    chk("t5:hold", bad, 0);

    // Reset during the write step of ADD
    hold_reset();
    clear_mem();
    ram[1] = 16'd2; ram[2] = 16'd3; ram[3] = 16'd7;
    rom[0] = 16'h1312;
    release_rst();
    bad = 0;
    while (!WR && bad < 10) begin
      step();
      bad++;
    end
    chk("t6:wb_reached", 32'(WR), 1);
    #2 rst = 1'b1;
    #1 chk("t6:wr_drop", 32'(WR), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("t6:r3_kept", 32'(ram[3]), 7);
    chk_reset("t6rst");
    release_rst();
    step();
    chk("t6:fetch_pc", 32'(pc), 0);
    step();
    chk("t6:led", 32'(led), 32'h13);

    for (int t = 0; t < 8; t++) begin
      hold_reset();
      g_ok = 1'b0;
      for (int tries = 0; tries < 50 && !g_ok; tries++) begin
        for (int i = 0; i < 16; i++)
          ram[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
        for (int i = 0; i < NW; i++)
          rom[i] = ($urandom_range(0, 11) == 0) ? 16'hA000
                                                 : 16'($urandom);
        for (int i = 0; i < 16; i++) m_r[i] = int'(ram[i]);
        iss(g_steps, g_hpc, g_ok);
      end
      go($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
